benzerlik_hesaplayici: RTL and testbench
========================================

# benzerlik_hesaplayici

Consumes the per-cycle nucleotide match bit produced by the nucleotide comparison stage. Accumulates it over a fixed-length sequence window and reports three results: the total match count, the longest run of consecutive matches, and a similarity flag against a threshold. It sits directly downstream of the comparison stage and presents one result set per sequence pair to the control/display logic.

## Interface
- UZUNLUK, 16: nucleotides per sequence (window length); ≥ 2.
- ESIK, 12: minimum match count for `benzer`=1; 0..UZUNLUK.
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- baslat  in  1  start request; accepted only in BOSTA.
- gecerli  in  1  `esles` carries a valid beat this cycle; caller aligns it with the registered match bit.
- esles  in  1  match bit from comparison stage (1 = nucleotides equal).
- mesgul  out  1  high in TOPLA and SONUC.
- hazir  out  1  one-cycle pulse: result outputs are fresh.
- eslesme_sayisi  out  SW  total matches in last window; SW = $clog2(UZUNLUK+1).
- en_uzun_seri  out  SW  longest consecutive-match run in last window.
- benzer  out  1  eslesme_sayisi ≥ ESIK.

## Operation
- Reset: all outputs 0, state BOSTA, internal counters 0. Applies immediately (async), mid-window included; the partial window is discarded, with no `hazir`.
- States:
  - BOSTA → TOPLA on `baslat`=1; position, match, current-run and longest-run counters clear on that edge.
  - TOPLA: each edge with `gecerli`=1 consumes one beat. Position +1. If `esles`=1: match +1 and run +1; otherwise run ← 0. Longest ← max(longest, new run).
  - `gecerli`=0 beats are ignored: no counter changes, and the run is not broken.
  - TOPLA → SONUC on the edge consuming beat UZUNLUK-1. On that edge, the output registers load final values, with the last beat included via next-state values.
  - SONUC → BOSTA unconditionally after one cycle.
- Result outputs hold their values until the next completed window or reset. They are not cleared on `baslat`.
- `baslat` in TOPLA or SONUC is ignored; there is no restart or abort.
- `baslat` in BOSTA and `gecerli` in the same cycle: the start is taken and that beat is ignored. Data beats count only from the cycle after the start.
- Counter width SW is sufficient for UZUNLUK. Counters never wrap within a window; position compares to UZUNLUK-1 exactly.
- `benzer` is computed from the next-state match count and registered with the other results.

## Timing
- The last beat is sampled at edge T. Results are valid and `hazir`=1 during cycle T→T+1 (SONUC). `mesgul` falls at edge T+1.
- A full window with continuous `gecerli` takes 1 (start) + UZUNLUK + 1 (SONUC) cycles from `baslat` to return to BOSTA.
- Earliest next `baslat` acceptance: edge T+1 is still SONUC and is ignored; edge T+2 is accepted.
- Minimum back-to-back period is UZUNLUK+2 cycles.
- No combinational path from inputs to outputs.

## Structure
- Shared package `dna_pkg`:
  - state enum {BOSTA, TOPLA, SONUC};
  - SW width helper;
  - 2-bit nucleotide encoding constants A/C/G/T, shared with the comparison stage.
- Sub-module `seri_izleyici`:
  - inputs: clk, rst, temizle, adim, esles;
  - outputs: current run and longest run (next-state values exposed for the final load).
- The top module holds the FSM, position/match counters and result registers.

## Test plan
- Continuous valid, 16× `esles`=1 → eslesme_sayisi=16, en_uzun_seri=16, benzer=1, `hazir` exactly 17 cycles after the `baslat` edge.
- Alternating 1,0,… for 16 beats → 8, 1, benzer=0.
- Pattern 0,1,1,1,1,1,0 then 1×9 → 14 matches, longest run=9, benzer=1. Insert random `gecerli`=0 gaps inside runs → identical results.
- Threshold boundary: 12 matches → benzer=1; 11 matches → benzer=0. Previous results are held through the next `baslat` until the new `hazir`.
- Assert `rst` after beat 7 → all outputs 0 asynchronously, no `hazir`. The next full window of all-ones → 16/16/1.
- `baslat` pulsed in TOPLA and SONUC → ignored, window length unaffected. `baslat`+`gecerli` in the same BOSTA cycle → that beat is not counted.

Source files
------------

// File: rtl/dna_pkg.sv
// Shared definitions for the DNA similarity datapath: FSM states,
// counter width helper and the 2-bit nucleotide encoding.
package dna_pkg;

  typedef enum logic [1:0] {
    BOSTA = 2'd0,
    TOPLA = 2'd1,
    SONUC = 2'd2
  } durum_t;

  // Counter width able to hold 0..n inclusive.
  function automatic int sayac_genisligi(input int n);
    return $clog2(n + 1);
  endfunction

  // Nucleotide encoding shared with the comparison stage.
  localparam logic [1:0] NUK_A = 2'b00;
  localparam logic [1:0] NUK_C = 2'b01;
  localparam logic [1:0] NUK_G = 2'b10;
  localparam logic [1:0] NUK_T = 2'b11;

endpackage

// File: rtl/benzerlik_hesaplayici_seri_izleyici.sv
// Run tracker: current run of consecutive matches and the longest run so far.
// Next-state values are exposed so the top can capture the final beat.
module seri_izleyici
  import dna_pkg::*;
#(
  parameter int SW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          temizle,
  input  logic          adim,
  input  logic          esles,
  output logic [SW-1:0] seri_sonraki,
  output logic [SW-1:0] en_uzun_sonraki
);

  logic [SW-1:0] seri;
  logic [SW-1:0] en_uzun;

  // Next run/longest values; a non-consumed beat leaves the run intact.
  always_comb begin
    seri_sonraki = seri;
    if (adim) seri_sonraki = esles ? seri + SW'(1) : '0;
    en_uzun_sonraki = (seri_sonraki > en_uzun) ? seri_sonraki : en_uzun;
  end

  // Run registers: cleared on window start, advanced on consumed beats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seri    <= '0;
      en_uzun <= '0;
    end else if (temizle) begin
      seri    <= '0;
      en_uzun <= '0;
    end else if (adim) begin
      seri    <= seri_sonraki;
      en_uzun <= en_uzun_sonraki;
    end
  end

endmodule

// File: rtl/benzerlik_hesaplayici.sv
// Similarity accumulator: counts matches over a fixed window, tracks the
// longest match run and flags the pair as similar against a threshold.
module benzerlik_hesaplayici
  import dna_pkg::*;
#(
  parameter int UZUNLUK = 16,
  parameter int ESIK    = 12,
  localparam int SW     = sayac_genisligi(UZUNLUK)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          baslat,
  input  logic          gecerli,
  input  logic          esles,
  output logic          mesgul,
  output logic          hazir,
  output logic [SW-1:0] eslesme_sayisi,
  output logic [SW-1:0] en_uzun_seri,
  output logic          benzer
);

  durum_t        durum, durum_sonraki;
  logic [SW-1:0] konum;
  logic [SW-1:0] sayac;
  logic [SW-1:0] sayac_sonraki;
  logic [SW-1:0] en_uzun_sonraki;
  logic [SW-1:0] seri_sonraki;
  logic          adim;
  logic          temizle;
  logic          son_adim;

  assign temizle       = (durum == BOSTA) && baslat;
  assign adim          = (durum == TOPLA) && gecerli;
  assign son_adim      = adim && (konum == SW'(UZUNLUK - 1));
  assign sayac_sonraki = sayac + SW'(adim && esles);

  seri_izleyici #(.SW(SW)) u_seri (
    .clk             (clk),
    .rst             (rst),
    .temizle         (temizle),
    .adim            (adim),
    .esles           (esles),
    .seri_sonraki    (seri_sonraki),
    .en_uzun_sonraki (en_uzun_sonraki)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) durum <= BOSTA;
    else     durum <= durum_sonraki;
  end

  // Next state: start only from idle, no abort, one result cycle.
  always_comb begin
    durum_sonraki = durum;
    case (durum)
      BOSTA:   if (baslat)   durum_sonraki = TOPLA;
      TOPLA:   if (son_adim) durum_sonraki = SONUC;
      SONUC:   durum_sonraki = BOSTA;
      default: durum_sonraki = BOSTA;
    endcase
  end

  // Status outputs decoded from the state register only.
  always_comb begin
    mesgul = (durum != BOSTA);
    hazir  = (durum == SONUC);
  end

  // Position and match counters for the window in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      konum <= '0;
      sayac <= '0;
    end else if (temizle) begin
      konum <= '0;
      sayac <= '0;
    end else if (adim) begin
      konum <= konum + SW'(1);
      sayac <= sayac_sonraki;
    end
  end

  // Result registers load on the final beat, including that beat; they
  // otherwise hold across later starts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eslesme_sayisi <= '0;
      en_uzun_seri   <= '0;
      benzer         <= 1'b0;
    end else if (son_adim) begin
      eslesme_sayisi <= sayac_sonraki;
      en_uzun_seri   <= en_uzun_sonraki;
      benzer         <= (sayac_sonraki >= SW'(ESIK));
    end
  end

endmodule

// File: tb/tb_benzerlik_hesaplayici.sv
// Directed bench for benzerlik_hesaplayici with hand-computed expectations.
module tb_benzerlik_hesaplayici;

  localparam int SW = 5;

  logic          clk;
  logic          rst;
  logic          baslat;
  logic          gecerli;
  logic          esles;
  logic          mesgul;
  logic          hazir;
  logic [SW-1:0] eslesme_sayisi;
  logic [SW-1:0] en_uzun_seri;
  logic          benzer;

  int kontrol_sayisi = 0;
  int hata_sayisi    = 0;
  int cevrim         = 0;
  int onceki_sayi    = 0;
  int onceki_seri    = 0;
  int onceki_benzer  = 0;

  benzerlik_hesaplayici #(.UZUNLUK(16), .ESIK(12)) dut (
    .clk            (clk),
    .rst            (rst),
    .baslat         (baslat),
    .gecerli        (gecerli),
    .esles          (esles),
    .mesgul         (mesgul),
    .hazir          (hazir),
    .eslesme_sayisi (eslesme_sayisi),
    .en_uzun_seri   (en_uzun_seri),
    .benzer         (benzer)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic kontrol(input string etiket, input logic [31:0] gozlenen,
                         input logic [31:0] beklenen);
    kontrol_sayisi++;
    assert (gozlenen === beklenen) else begin
      hata_sayisi++;
      $error("FAIL %s: gozlenen=%0d beklenen=%0d", etiket, gozlenen, beklenen);
    end
  endtask

  // Drive one cycle of inputs at a falling edge, return at the next one.
  task automatic tik(input logic b, input logic g, input logic e);
    baslat  = b;
    gecerli = g;
    esles   = e;
    @(negedge clk);
    cevrim++;
  endtask

  // One window: start step, optional gap before each beat, optional
  // baslat held during beats. Patterns are consumed MSB first.
  task automatic pencere(input string etiket, input logic [15:0] desen,
                         input logic [15:0] bosluk, input logic baslat_tekrar,
                         input logic ayni_anda);
    cevrim = 0;
    tik(1'b1, ayni_anda, 1'b1);
    for (int i = 0; i < 16; i++) begin
      if (bosluk[15-i]) tik(baslat_tekrar, 1'b0, 1'($urandom_range(1, 0)));
      if (i == 8) begin
        kontrol({etiket, "_tut_sayi"}, 32'(eslesme_sayisi), 32'(onceki_sayi));
        kontrol({etiket, "_tut_seri"}, 32'(en_uzun_seri), 32'(onceki_seri));
        kontrol({etiket, "_tut_benzer"}, 32'(benzer), 32'(onceki_benzer));
      end
      if (i == 15) begin
        kontrol({etiket, "_erken_hazir"}, 32'(hazir), 32'd0);
        kontrol({etiket, "_mesgul"}, 32'(mesgul), 32'd1);
      end
      tik(baslat_tekrar, 1'b1, desen[15-i]);
    end
  endtask

  // Check result cycle, then step through SONUC back to idle.
  task automatic sonuc(input string etiket, input int sayi, input int seri,
                       input int bnz, input logic sonuc_baslat);
    kontrol({etiket, "_hazir"}, 32'(hazir), 32'd1);
    kontrol({etiket, "_sayi"}, 32'(eslesme_sayisi), 32'(sayi));
    kontrol({etiket, "_seri"}, 32'(en_uzun_seri), 32'(seri));
    kontrol({etiket, "_benzer"}, 32'(benzer), 32'(bnz));
    onceki_sayi   = sayi;
    onceki_seri   = seri;
    onceki_benzer = bnz;
    tik(sonuc_baslat, 1'b0, 1'b0);
    kontrol({etiket, "_bosta_mesgul"}, 32'(mesgul), 32'd0);
    kontrol({etiket, "_bosta_hazir"}, 32'(hazir), 32'd0);
  endtask

  initial begin
    rst = 1'b1; baslat = 1'b0; gecerli = 1'b0; esles = 1'b0;
    @(negedge clk);
    @(negedge clk);
    kontrol("rst_mesgul", 32'(mesgul), 32'd0);
    kontrol("rst_hazir", 32'(hazir), 32'd0);
    kontrol("rst_sayi", 32'(eslesme_sayisi), 32'd0);
    kontrol("rst_seri", 32'(en_uzun_seri), 32'd0);
    kontrol("rst_benzer", 32'(benzer), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // All ones, continuous valid; hazir after 17 cycles from baslat.
    pencere("birler", 16'hFFFF, 16'h0000, 1'b0, 1'b0);
    kontrol("birler_gecikme", 32'(cevrim), 32'd17);
    sonuc("birler", 16, 16, 1, 1'b0);

    // Alternating 1,0,...
    pencere("almasik", 16'hAAAA, 16'h0000, 1'b0, 1'b0);
    sonuc("almasik", 8, 1, 0, 1'b0);

    // 0,1,1,1,1,1,0 then nine 1s.
    pencere("desen", 16'h7DFF, 16'h0000, 1'b0, 1'b0);
    sonuc("desen", 14, 9, 1, 1'b0);

    // Same pattern with idle gaps inside runs.
    pencere("bosluklu", 16'h7DFF, 16'h2A94, 1'b0, 1'b0);
    sonuc("bosluklu", 14, 9, 1, 1'b0);

    // Threshold boundary: 12 matches then 11 matches.
    pencere("esik12", 16'hF0FF, 16'h0000, 1'b0, 1'b0);
    sonuc("esik12", 12, 8, 1, 1'b0);
    pencere("esik11", 16'hEFF0, 16'h0000, 1'b0, 1'b0);
    sonuc("esik11", 11, 8, 0, 1'b0);

    // Async reset after beat 7 of an all-ones window.
    cevrim = 0;
    tik(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) tik(1'b0, 1'b1, 1'b1);
    #2 rst = 1'b1;
    #1;
    kontrol("arst_mesgul", 32'(mesgul), 32'd0);
    kontrol("arst_hazir", 32'(hazir), 32'd0);
    kontrol("arst_sayi", 32'(eslesme_sayisi), 32'd0);
    kontrol("arst_seri", 32'(en_uzun_seri), 32'd0);
    kontrol("arst_benzer", 32'(benzer), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    onceki_sayi = 0; onceki_seri = 0; onceki_benzer = 0;
    for (int i = 0; i < 12; i++) begin
      tik(1'b0, 1'b1, 1'b1);
      kontrol("arst_sonra_hazir", 32'(hazir), 32'd0);
    end
    pencere("arst_birler", 16'hFFFF, 16'h0000, 1'b0, 1'b0);
    sonuc("arst_birler", 16, 16, 1, 1'b0);

    // baslat held through TOPLA and in SONUC: ignored, length unchanged.
    pencere("baslat_yoksay", 16'hAAAA, 16'h0410, 1'b1, 1'b0);
    sonuc("baslat_yoksay", 8, 1, 0, 1'b1);

    // baslat with a matching beat in the same cycle: that beat is dropped.
    pencere("ayni_anda", 16'h0000, 16'h0000, 1'b0, 1'b1);
    sonuc("ayni_anda", 0, 0, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", kontrol_sayisi, hata_sayisi);
    $finish;
  end

  // Overall bound so a stuck run still terminates.
  initial begin
    #200000;
    $display("FAIL zaman_asimi: bench did not reach the end");
    $fatal(1, "zaman asimi");
  end

endmodule
